// File: rtl/emin_argmin.sv
// emin_argmin: consumes the Emin(j,i) stream for one segmentation row i,
// forms cost(j) = E[j-1] + Emin(j,i) + PENALTY (E[-1] = 0), tracks the
// minimum and its argmin, and commits E[i]/bp[i] to internal tables.
// A registered read port serves the backtrack stage.
module emin_argmin #(
  parameter int                          BIT_WIDTH = 32,
  parameter int                          I         = 160,
  parameter logic signed [BIT_WIDTH-1:0] PENALTY   = '0,
  localparam int                         IW        = $clog2(I)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [IW-1:0]        i_in,
  input  logic [IW-1:0]        j_in,
  input  logic [BIT_WIDTH-1:0] emin_in,
  input  logic                 valid_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [BIT_WIDTH-1:0] e_out,
  output logic [IW-1:0]        bp_out,
  output logic                 err_out,
  input  logic [IW-1:0]        rd_addr_in,
  output logic [BIT_WIDTH-1:0] rd_e_out,
  output logic [IW-1:0]        rd_bp_out
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_COMMIT} state_t;

  localparam logic signed [BIT_WIDTH-1:0] MAX_V   = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [BIT_WIDTH+1:0] MAX_EXT = {3'b000, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [BIT_WIDTH+1:0] MIN_EXT = {3'b111, {(BIT_WIDTH-1){1'b0}}};

  state_t state, state_next;

  logic signed [BIT_WIDTH-1:0] e_tab [I];
  logic [IW-1:0]               bp_tab [I];

  logic [IW-1:0]               i_lat;
  logic [IW-1:0]               exp_j;
  logic                        last_seen;
  logic                        s1_valid;
  logic                        s1_last;
  logic [IW-1:0]               s1_j;
  logic signed [BIT_WIDTH-1:0] s1_cost;
  logic signed [BIT_WIDTH-1:0] min_cost;
  logic [IW-1:0]               argmin;

  logic                        accept_start;
  logic                        take_sample;
  logic                        commit;

  logic signed [BIT_WIDTH-1:0] prev_e;
  logic signed [BIT_WIDTH+1:0] sum;
  logic signed [BIT_WIDTH-1:0] cost_sat;

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic: ACCUM ends once the stage-2 sample carries the last flag
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start_in) state_next = S_ACCUM;
      S_ACCUM:  if (s1_valid && s1_last) state_next = S_COMMIT;
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // State-decoded controls; samples after the last one of a row are dropped
  always_comb begin
    accept_start = 1'b0;
    take_sample  = 1'b0;
    commit       = 1'b0;
    unique case (state)
      S_IDLE:   accept_start = start_in;
      S_ACCUM:  take_sample  = valid_in && !last_seen;
      S_COMMIT: commit       = 1'b1;
      default:  ;
    endcase
  end

  // Cost of the incoming sample: E[j-1] lookup, wide sum, signed saturation
  always_comb begin
    prev_e = '0;
    if (j_in != '0 && int'(j_in) <= I) prev_e = e_tab[j_in - 1'b1];
    sum = {{2{prev_e[BIT_WIDTH-1]}}, prev_e}
        + {{2{emin_in[BIT_WIDTH-1]}}, emin_in}
        + {{2{PENALTY[BIT_WIDTH-1]}}, PENALTY};
    if (sum > MAX_EXT)      cost_sat = MAX_V;
    else if (sum < MIN_EXT) cost_sat = ~MAX_V;
    else                    cost_sat = sum[BIT_WIDTH-1:0];
  end

  // Row datapath: start latch, stage-1 register, stage-2 min tracking, commit outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      e_out     <= '0;
      bp_out    <= '0;
      err_out   <= 1'b0;
      i_lat     <= '0;
      exp_j     <= '0;
      last_seen <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_j      <= '0;
      s1_cost   <= '0;
      min_cost  <= '0;
      argmin    <= '0;
    end else begin
      done_out <= 1'b0;
      s1_valid <= 1'b0;
      if (accept_start) begin
        busy_out  <= 1'b1;
        i_lat     <= i_in;
        min_cost  <= MAX_V;
        argmin    <= '0;
        exp_j     <= '0;
        err_out   <= 1'b0;
        last_seen <= 1'b0;
      end
      if (take_sample) begin
        s1_valid <= 1'b1;
        s1_cost  <= cost_sat;
        s1_j     <= j_in;
        s1_last  <= (j_in == i_lat);
        if (j_in == i_lat) last_seen <= 1'b1;
        if (j_in != exp_j) err_out <= 1'b1;
        exp_j    <= j_in + 1'b1;
      end
      if (state == S_ACCUM && s1_valid && s1_cost < min_cost) begin
        min_cost <= s1_cost;
        argmin   <= s1_j;
      end
      if (commit) begin
        done_out <= 1'b1;
        busy_out <= 1'b0;
        e_out    <= min_cost;
        bp_out   <= argmin;
      end
    end
  end

  // Registered read port (sees the pre-write value during a commit cycle)
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_e_out  <= '0;
      rd_bp_out <= '0;
    end else if (int'(rd_addr_in) < I) begin
      rd_e_out  <= e_tab[rd_addr_in];
      rd_bp_out <= bp_tab[rd_addr_in];
    end else begin
      rd_e_out  <= '0;
      rd_bp_out <= '0;
    end
  end

  // Table write on commit; tables are not reset so earlier rows survive rst_in
  always_ff @(posedge clk_in) begin
    if (commit && int'(i_lat) < I) begin
      e_tab[i_lat]  <= min_cost;
      bp_tab[i_lat] <= argmin;
    end
  end

endmodule
